mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter OPC_W, default 4, opcode field width.
REQ-002 SHALL have parameter FUNC_W, default 4, function field width.
REQ-003 SHALL have parameter MEM_WAIT_EN, default 1; 1 = fetch and memory states wait for mem_ready, 0 = mem_ready ignored.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port opcode, input, OPC_W, instruction register opcode field.
REQ-007 SHALL have port func_field, input, FUNC_W, instruction register function field.
REQ-008 SHALL have port mem_ready, input, 1, memory transfer complete this cycle.
REQ-009 SHALL have port pc_src, output, 2, 00 = ALU result, 01 = jump target.
REQ-010 SHALL have port alu_op, output, 3, 000 add, 001 sub, 010 nand, 011 sll, 100 srl, 101 or, 110 sra.
REQ-011 SHALL have port sign_extend, output, 1, 1 = sign-extend immediate.
REQ-012 SHALL have port alu_src_a, output, 1, 0 = PC, 1 = register A.
REQ-013 SHALL have port alu_src_b, output, 3, 000 reg B, 001 constant 1, 010 imm, 011 mem offset, 100 jump offset.
REQ-014 SHALL have port read_r1, output, 2, 00 rs, 01 rd, 10 base; and port read_r2, output, 1, 0 rt, 1 store data.
REQ-015 SHALL have ports reg_write_dst, mem_to_reg, pc_beq_cond, pc_bnq_cond, pc_write, mem_write, mem_read, ir_write, reg_write, each output, 1, with the existing datapath meanings.
REQ-016 SHALL have ports halted, output, 1, level, core stopped; and illegal_op, output, 1, one-cycle pulse on an undefined instruction.

Function
REQ-017 SHALL implement a Moore FSM with states FETCH, DECODE, EX_ALU, EX_ADDR, EX_BR, EX_JMP, MEM_RD, MEM_WR, WB_ALU, WB_LW, HALT and ILLEGAL; all outputs are a function of the state plus the latched opcode/func only.
REQ-018 SHALL latch opcode and func_field into internal registers on the DECODE cycle; the EX and later states use the latched copies only.
REQ-019 SHALL drive every output not asserted in a state to 0 (no X values).
REQ-020 FETCH: mem_read=1, alu_src_a=0, alu_src_b=001, alu_op=000; pc_write=1 and ir_write=1 only in the cycle where mem_ready=1 (always when MEM_WAIT_EN=0); the FSM SHALL stay in FETCH until then.
REQ-021 DECODE -> EX_ALU for add/addi1/addi2/sub/subi1/subi2/nand/nandi/or/ori and for shift with func 1/2/3; -> EX_ADDR for lw/sw; -> EX_BR for beq/bnq; -> EX_JMP for jmp; -> HALT for shift with func 0; -> ILLEGAL for shift with func 4..F.
REQ-022 EX_ALU: alu_src_a=1; alu_src_b=000 for register forms, 010 for immediate forms; sign_extend=1 for addi1/subi1/ori and 0 otherwise; alu_op per REQ-010; read_r1=01 for immediate forms; next state is WB_ALU.
REQ-023 WB_ALU: reg_write=1, reg_write_dst=1, mem_to_reg=0; next state is FETCH.
REQ-024 EX_ADDR: alu_src_a=1, alu_src_b=011, sign_extend=1, read_r1=10, read_r2=1; next state is MEM_RD for lw, MEM_WR for sw.
REQ-025 MEM_RD asserts mem_read=1; MEM_WR asserts mem_write=1 and read_r2=1; each SHALL hold until mem_ready=1, then go to WB_LW or FETCH respectively.
REQ-026 WB_LW: reg_write=1, reg_write_dst=1, mem_to_reg=1; next state is FETCH.
REQ-027 EX_BR: alu_op=001, alu_src_a=1, alu_src_b=000, pc_src=00; pc_beq_cond=1 for beq, pc_bnq_cond=1 for bnq; next state is FETCH. EX_JMP: pc_src=01, alu_src_b=100, pc_write=1; next state is FETCH.
REQ-028 ILLEGAL SHALL pulse illegal_op for one cycle and then go to FETCH; HALT SHALL assert halted with all other outputs 0 and remain until rst.
REQ-029 Latencies with no wait states SHALL be: ALU and sw 4 cycles, lw 5, branch and jmp 3; each cycle of mem_ready=0 in a waiting state adds exactly one cycle.

Reset
REQ-030 rst=1 at a clock edge SHALL force FETCH, clear the latched opcode/func, and deassert halted; rst overrides every transition, including mid-wait and HALT.
REQ-031 While in FETCH after reset, outputs SHALL equal the FETCH values (mem_read=1) and every other write enable SHALL be 0.

Structure
REQ-032 Opcode, function-code, alu_op and alu_src_b encodings and the state encoding SHALL live in a shared package, mc_ctrl_pkg.
REQ-033 The design SHALL be a single module with no sub-modules; next-state logic and output decode are separate combinational processes.

Verification
REQ-034 Test add (opcode 1000) with mem_ready held at 1 -> states FETCH, DECODE, EX_ALU, WB_ALU; reg_write=1 only in cycle 4.
REQ-035 Test lw (0001) with mem_ready=0 for 2 cycles in MEM_RD -> 7 cycles total; mem_to_reg=1 and reg_write=1 in the last cycle.
REQ-036 Test sll (0000/0001) -> alu_op=011 in EX_ALU; test nand (1011) -> alu_op=010.
REQ-037 Test opcode 0000 with func 0101 -> one illegal_op pulse, then FETCH; test func 0000 -> halted=1 held for 10 cycles, then rst -> FETCH.
REQ-038 Assert rst during a MEM_WR wait -> FETCH on the next edge, with no mem_write in the following cycle; with MEM_WAIT_EN=0 and mem_ready=0, lw still completes in 5 cycles.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle controller.
// Opcodes, function codes, ALU ops, ALU B-source selects and FSM states.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_ALU  = 4'd2,
    S_EX_ADDR = 4'd3,
    S_EX_BR   = 4'd4,
    S_EX_JMP  = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_WB_LW   = 4'd9,
    S_HALT    = 4'd10,
    S_ILLEGAL = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_MEM,
    C_BR,
    C_JMP,
    C_HALT,
    C_ILL
  } iclass_t;

  localparam logic [3:0] OP_SHIFT = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_BNQ   = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_ADDI1 = 4'b1001;
  localparam logic [3:0] OP_ADDI2 = 4'b1010;
  localparam logic [3:0] OP_NAND  = 4'b1011;
  localparam logic [3:0] OP_NANDI = 4'b1100;
  localparam logic [3:0] OP_SUB   = 4'b1101;
  localparam logic [3:0] OP_SUBI1 = 4'b1110;
  localparam logic [3:0] OP_SUBI2 = 4'b1111;

  localparam logic [3:0] FN_HALT = 4'd0;
  localparam logic [3:0] FN_SLL  = 4'd1;
  localparam logic [3:0] FN_SRL  = 4'd2;
  localparam logic [3:0] FN_SRA  = 4'd3;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_NAND = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;

  localparam logic [2:0] SRCB_REG = 3'b000;
  localparam logic [2:0] SRCB_ONE = 3'b001;
  localparam logic [2:0] SRCB_IMM = 3'b010;
  localparam logic [2:0] SRCB_MEM = 3'b011;
  localparam logic [2:0] SRCB_JMP = 3'b100;

  localparam logic [1:0] R1_RS   = 2'b00;
  localparam logic [1:0] R1_RD   = 2'b01;
  localparam logic [1:0] R1_BASE = 2'b10;

endpackage

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM control unit for a multi-cycle datapath.
// In: clk, rst (sync, high), opcode, func_field, mem_ready.
// Out: datapath selects/enables, halted (level), illegal_op (pulse).
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned FUNC_W      = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func_field,
  input  logic              mem_ready,
  output logic [1:0]        pc_src,
  output logic [2:0]        alu_op,
  output logic              sign_extend,
  output logic              alu_src_a,
  output logic [2:0]        alu_src_b,
  output logic [1:0]        read_r1,
  output logic              read_r2,
  output logic              reg_write_dst,
  output logic              mem_to_reg,
  output logic              pc_beq_cond,
  output logic              pc_bnq_cond,
  output logic              pc_write,
  output logic              mem_write,
  output logic              mem_read,
  output logic              ir_write,
  output logic              reg_write,
  output logic              halted,
  output logic              illegal_op
);

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic                mem_ok;

  assign mem_ok = !MEM_WAIT_EN || mem_ready;

  function automatic logic is_alu(input logic [OPC_W-1:0] op);
    return op inside {
      OPC_W'(OP_ADD), OPC_W'(OP_ADDI1), OPC_W'(OP_ADDI2),
      OPC_W'(OP_SUB), OPC_W'(OP_SUBI1), OPC_W'(OP_SUBI2),
      OPC_W'(OP_NAND), OPC_W'(OP_NANDI),
      OPC_W'(OP_OR), OPC_W'(OP_ORI)};
  endfunction

  function automatic logic is_imm(input logic [OPC_W-1:0] op);
    return op inside {
      OPC_W'(OP_ADDI1), OPC_W'(OP_ADDI2),
      OPC_W'(OP_SUBI1), OPC_W'(OP_SUBI2),
      OPC_W'(OP_NANDI), OPC_W'(OP_ORI)};
  endfunction

  function automatic logic is_sext(input logic [OPC_W-1:0] op);
    return op inside {
      OPC_W'(OP_ADDI1), OPC_W'(OP_SUBI1), OPC_W'(OP_ORI)};
  endfunction

  function automatic iclass_t classify(
    input logic [OPC_W-1:0]  op,
    input logic [FUNC_W-1:0] fn
  );
    iclass_t c;
    c = C_ILL;
    if (op == OPC_W'(OP_SHIFT)) begin
      // func 0 doubles as the halt instruction
      if (fn == FUNC_W'(FN_HALT))
        c = C_HALT;
      else if (fn <= FUNC_W'(FN_SRA))
        c = C_ALU;
    end else if (op == OPC_W'(OP_LW) || op == OPC_W'(OP_SW)) begin
      c = C_MEM;
    end else if (op == OPC_W'(OP_BEQ) || op == OPC_W'(OP_BNQ)) begin
      c = C_BR;
    end else if (op == OPC_W'(OP_JMP)) begin
      c = C_JMP;
    end else if (is_alu(op)) begin
      c = C_ALU;
    end
    return c;
  endfunction

  function automatic logic [2:0] alu_sel(
    input logic [OPC_W-1:0]  op,
    input logic [FUNC_W-1:0] fn
  );
    logic [2:0] a;
    a = ALU_ADD;
    if (op == OPC_W'(OP_SHIFT)) begin
      unique case (1'b1)
        fn == FUNC_W'(FN_SLL): a = ALU_SLL;
        fn == FUNC_W'(FN_SRL): a = ALU_SRL;
        fn == FUNC_W'(FN_SRA): a = ALU_SRA;
        default:               a = ALU_ADD;
      endcase
    end else begin
      unique case (1'b1)
        op inside {OPC_W'(OP_SUB), OPC_W'(OP_SUBI1),
                   OPC_W'(OP_SUBI2)}:           a = ALU_SUB;
        op inside {OPC_W'(OP_NAND),
                   OPC_W'(OP_NANDI)}:           a = ALU_NAND;
        op inside {OPC_W'(OP_OR),
                   OPC_W'(OP_ORI)}:             a = ALU_OR;
        default:                                a = ALU_ADD;
      endcase
    end
    return a;
  endfunction

  // Instruction fields are captured as DECODE ends; later states
  // must not depend on the live IR bus.
  assign opc_d  = (state_q == S_DECODE) ? opcode : opc_q;
  assign func_d = (state_q == S_DECODE) ? func_field : func_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      func_q  <= func_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        unique case (classify(opcode, func_field))
          C_ALU:   state_d = S_EX_ALU;
          C_MEM:   state_d = S_EX_ADDR;
          C_BR:    state_d = S_EX_BR;
          C_JMP:   state_d = S_EX_JMP;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_EX_ALU:  state_d = S_WB_ALU;
      S_EX_ADDR: state_d = (opc_q == OPC_W'(OP_LW)) ? S_MEM_RD
                                                   : S_MEM_WR;
      S_MEM_RD:  if (mem_ok) state_d = S_WB_LW;
      S_MEM_WR:  if (mem_ok) state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_src        = 2'b00;
    alu_op        = ALU_ADD;
    sign_extend   = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    read_r1       = R1_RS;
    read_r2       = 1'b0;
    reg_write_dst = 1'b0;
    mem_to_reg    = 1'b0;
    pc_beq_cond   = 1'b0;
    pc_bnq_cond   = 1'b0;
    pc_write      = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    halted        = 1'b0;
    illegal_op    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        // PC and IR only update on the cycle the fetch completes
        pc_write  = mem_ok;
        ir_write  = mem_ok;
      end
      S_EX_ALU: begin
        alu_src_a   = 1'b1;
        alu_op      = alu_sel(opc_q, func_q);
        sign_extend = is_sext(opc_q);
        if (is_imm(opc_q)) begin
          alu_src_b = SRCB_IMM;
          read_r1   = R1_RD;
        end
      end
      S_WB_ALU: begin
        reg_write     = 1'b1;
        reg_write_dst = 1'b1;
      end
      S_EX_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_MEM;
        sign_extend = 1'b1;
        read_r1     = R1_BASE;
        read_r2     = 1'b1;
      end
      S_MEM_RD: mem_read = 1'b1;
      S_MEM_WR: begin
        mem_write = 1'b1;
        read_r2   = 1'b1;
      end
      S_WB_LW: begin
        reg_write     = 1'b1;
        reg_write_dst = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_EX_BR: begin
        alu_op      = ALU_SUB;
        alu_src_a   = 1'b1;
        pc_beq_cond = (opc_q == OPC_W'(OP_BEQ));
        pc_bnq_cond = (opc_q == OPC_W'(OP_BNQ));
      end
      S_EX_JMP: begin
        pc_src    = 2'b01;
        alu_src_b = SRCB_JMP;
        pc_write  = 1'b1;
      end
      S_HALT:    halted = 1'b1;
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule
